// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline MEM stage issuing toggle-handshake RAM requests
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_o,
    output logic        ram_r_req_o,
    output logic        ram_w_req_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    output logic [1:0]  ram_state_o,
    output logic        ram_sync_o,
    input  logic        ram_sync_i,
    input  logic [31:0] ram_data_i
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    logic [31:0] rdata;
    logic [2:0]  req_funct3;
    logic        req_load;
    logic        f3_legal;
    logic [1:0]  size_code;
    logic        valid_op;
    logic        ack;
    logic [31:0] load_ext;

    // size_code is bytes-1; encodings 011/110/111 make the op a plain ALU op
    always_comb begin
        f3_legal  = 1'b0;
        size_code = 2'd0;
        case (funct3_i)
            3'b000, 3'b100: begin f3_legal = 1'b1; size_code = 2'd0; end
            3'b001, 3'b101: begin f3_legal = 1'b1; size_code = 2'd1; end
            3'b010:         begin f3_legal = 1'b1; size_code = 2'd3; end
            default:        begin f3_legal = 1'b0; size_code = 2'd0; end
        endcase
    end

    assign valid_op = (mem_re_i ^ mem_we_i) & f3_legal;
    assign ack      = (ram_sync_i == ram_sync_o);
    assign wd_o     = wd_i;

    // Upper bytes beyond the access width are stale controller data and are discarded
    always_comb begin
        load_ext = ram_data_i;
        case (req_funct3)
            3'b000:  load_ext = {{24{ram_data_i[7]}}, ram_data_i[7:0]};
            3'b001:  load_ext = {{16{ram_data_i[15]}}, ram_data_i[15:0]};
            3'b100:  load_ext = {24'h0, ram_data_i[7:0]};
            3'b101:  load_ext = {16'h0, ram_data_i[15:0]};
            default: load_ext = ram_data_i;
        endcase
    end

    always_comb begin
        stall_o = 1'b0;
        wreg_o  = wreg_i;
        wdata_o = wdata_i;
        case (state)
            IDLE: begin
                if (valid_op) begin
                    stall_o = 1'b1;
                    wreg_o  = 1'b0;
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                wreg_o  = 1'b0;
            end
            DONE: begin
                wreg_o = wreg_i & req_load;
                if (req_load) begin
                    wdata_o = rdata;
                end
            end
            default: begin
                stall_o = 1'b0;
            end
        endcase
    end

    // DONE always returns to IDLE so the still-present instruction is not reissued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ram_sync_o  <= 1'b0;
            ram_r_req_o <= 1'b0;
            ram_w_req_o <= 1'b0;
            ram_addr_o  <= 32'h0;
            ram_data_o  <= 32'h0;
            ram_state_o <= 2'd0;
            rdata       <= 32'h0;
            req_funct3  <= 3'b000;
            req_load    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_op) begin
                        ram_addr_o  <= addr_i;
                        ram_data_o  <= wdata_i;
                        ram_state_o <= size_code;
                        req_funct3  <= funct3_i;
                        req_load    <= mem_re_i;
                        ram_r_req_o <= mem_re_i;
                        ram_w_req_o <= mem_we_i;
                        ram_sync_o  <= ~ram_sync_o;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (ack) begin
                        rdata       <= load_ext;
                        ram_r_req_o <= 1'b0;
                        ram_w_req_o <= 1'b0;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage with a latency-programmable controller model
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        mem_re_i;
    logic        mem_we_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_o;
    logic        ram_r_req_o;
    logic        ram_w_req_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [1:0]  ram_state_o;
    logic        ram_sync_o;
    logic        ram_sync_i = 1'b0;
    logic [31:0] ram_data_i = 32'h0;

    int          checks = 0;
    int          failures = 0;
    int          ctrl_lat = 1;
    int          ctrl_cnt = 0;
    logic [31:0] ctrl_data = 32'h0;
    int          sync_edges = 0;

    int          o_stalls;
    int          o_toggles;
    logic        o_r, o_w, o_wreg, o_wreg_stall, o_req_done, o_timeout;
    logic [31:0] o_addr, o_data, o_wdata;
    logic [1:0]  o_state;
    logic [4:0]  o_wd;

    mem_stage dut (
        .clk(clk), .rst(rst),
        .mem_re_i(mem_re_i), .mem_we_i(mem_we_i), .funct3_i(funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stall_o(stall_o),
        .ram_r_req_o(ram_r_req_o), .ram_w_req_o(ram_w_req_o),
        .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o), .ram_state_o(ram_state_o),
        .ram_sync_o(ram_sync_o), .ram_sync_i(ram_sync_i), .ram_data_i(ram_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(ram_sync_o) sync_edges++;

    // Controller: answers the ctrl_lat-th cycle after a request; data bus is junk otherwise
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            ctrl_cnt   = 0;
            ram_sync_i = 1'b0;
        end else if (ram_sync_o != ram_sync_i) begin
            ctrl_cnt++;
            if (ctrl_cnt >= ctrl_lat) begin
                ram_sync_i = ram_sync_o;
                ram_data_i = ctrl_data;
                ctrl_cnt   = 0;
            end else begin
                ram_data_i = $urandom;
            end
        end else begin
            ram_data_i = $urandom;
        end
    end

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] raw);
        longint unsigned span;
        longint unsigned v;
        bit              sgn;
        case (f3)
            3'd0:    begin span = 64'd256;         sgn = 1'b1; end
            3'd1:    begin span = 64'd65536;       sgn = 1'b1; end
            3'd4:    begin span = 64'd256;         sgn = 1'b0; end
            3'd5:    begin span = 64'd65536;       sgn = 1'b0; end
            default: begin span = 64'h1_0000_0000; sgn = 1'b0; end
        endcase
        v = {32'h0, raw} % span;
        if (sgn && v >= span / 2) v = v + 64'h1_0000_0000 - span;
        return v[31:0];
    endfunction

    function automatic logic [1:0] ref_state(input logic [2:0] f3);
        int nbytes;
        nbytes = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
        return 2'(nbytes - 1);
    endfunction

    task automatic run_op(input logic re, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input logic wr, input int lat, input logic [31:0] raw);
        int e0;
        @(posedge clk);
        #2;
        ctrl_lat = lat;
        ctrl_data = raw;
        mem_re_i = re; mem_we_i = we; funct3_i = f3;
        addr_i = a; wdata_i = d; wd_i = rd; wreg_i = wr;
        e0 = sync_edges;
        o_stalls = 0; o_r = 0; o_w = 0; o_addr = 0; o_data = 0; o_state = 0;
        o_wreg_stall = 0; o_req_done = 0; o_timeout = 1; o_wdata = 0; o_wreg = 0; o_wd = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (ram_r_req_o) o_r = 1'b1;
            if (ram_w_req_o) o_w = 1'b1;
            if (ram_r_req_o || ram_w_req_o) begin
                o_addr = ram_addr_o; o_data = ram_data_o; o_state = ram_state_o;
            end
            if (stall_o) begin
                o_stalls++;
                if (wreg_o) o_wreg_stall = 1'b1;
            end else begin
                o_wdata = wdata_o; o_wreg = wreg_o; o_wd = wd_o;
                o_req_done = ram_r_req_o | ram_w_req_o;
                o_timeout = 1'b0;
                break;
            end
        end
        o_toggles = sync_edges - e0;
    endtask

    task automatic idle_inputs;
        @(posedge clk);
        #2;
        mem_re_i = 1'b0; mem_we_i = 1'b0; funct3_i = 3'b000; wreg_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        mem_re_i = 1'b0; mem_we_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'h0; wdata_i = 32'h1234_5678; wd_i = 5'd3; wreg_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        checks++; if ({ram_r_req_o, ram_w_req_o, ram_sync_o} !== 3'b000) begin failures++; $display("FAIL reset_req got=%b exp=000", {ram_r_req_o, ram_w_req_o, ram_sync_o}); end
        checks++; if ({ram_addr_o, ram_data_o, ram_state_o} !== 66'h0) begin failures++; $display("FAIL reset_regs got=%h/%h/%h exp=0", ram_addr_o, ram_data_o, ram_state_o); end
        checks++; if (wdata_o !== 32'h1234_5678 || wreg_o !== 1'b1 || wd_o !== 5'd3) begin failures++; $display("FAIL reset_pass got=%h/%b/%0d exp=12345678/1/3", wdata_o, wreg_o, wd_o); end
        @(posedge clk);
        #2;
        rst = 1'b1;
        wreg_i = 1'b0;
    endtask

    task automatic test_lb;
        run_op(1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 5'd7, 1'b1, 6, 32'h1234_5680);
        checks++; if (o_stalls != 7) begin failures++; $display("FAIL lb_stall got=%0d exp=7", o_stalls); end
        checks++; if (o_r !== 1'b1 || o_w !== 1'b0) begin failures++; $display("FAIL lb_req got=r%b w%b exp=r1 w0", o_r, o_w); end
        checks++; if (o_state !== 2'd0 || o_addr !== 32'h100) begin failures++; $display("FAIL lb_state_addr got=%0d/%h exp=0/00000100", o_state, o_addr); end
        checks++; if (o_wdata !== 32'hFFFF_FF80 || o_wreg !== 1'b1) begin failures++; $display("FAIL lb_done got=%h/%b exp=ffffff80/1", o_wdata, o_wreg); end
        checks++; if (o_wreg_stall !== 1'b0 || o_req_done !== 1'b0) begin failures++; $display("FAIL lb_side got=%b/%b exp=0/0", o_wreg_stall, o_req_done); end
        idle_inputs();
    endtask

    task automatic test_lhu_lh;
        run_op(1'b1, 1'b0, 3'b101, 32'h204, 32'h0, 5'd8, 1'b1, 3, 32'hAAAA_8001);
        checks++; if (o_state !== 2'd1) begin failures++; $display("FAIL lhu_state got=%0d exp=1", o_state); end
        checks++; if (o_wdata !== 32'h0000_8001) begin failures++; $display("FAIL lhu_data got=%h exp=00008001", o_wdata); end
        idle_inputs();
        run_op(1'b1, 1'b0, 3'b001, 32'h204, 32'h0, 5'd8, 1'b1, 2, 32'hAAAA_8001);
        checks++; if (o_wdata !== 32'hFFFF_8001) begin failures++; $display("FAIL lh_data got=%h exp=ffff8001", o_wdata); end
        idle_inputs();
    endtask

    task automatic test_sh;
        run_op(1'b0, 1'b1, 3'b001, 32'h1002, 32'hDEAD_BEEF, 5'd9, 1'b1, 3, 32'h0);
        checks++; if (o_w !== 1'b1 || o_r !== 1'b0) begin failures++; $display("FAIL sh_req got=r%b w%b exp=r0 w1", o_r, o_w); end
        checks++; if (o_addr !== 32'h1002 || o_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sh_addr_data got=%h/%h exp=00001002/deadbeef", o_addr, o_data); end
        checks++; if (o_state !== 2'd1) begin failures++; $display("FAIL sh_state got=%0d exp=1", o_state); end
        checks++; if (o_wreg_stall !== 1'b0 || o_wreg !== 1'b0) begin failures++; $display("FAIL sh_wreg got=%b/%b exp=0/0", o_wreg_stall, o_wreg); end
        checks++; if (o_stalls != 4 || o_wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL sh_done got=%0d/%h exp=4/deadbeef", o_stalls, o_wdata); end
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        int   e0;
        logic s0;
        e0 = sync_edges;
        s0 = ram_sync_o;
        run_op(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 5'd10, 1'b1, 2, 32'hCAFE_F00D);
        checks++; if (o_wdata !== 32'hCAFE_F00D || o_wreg !== 1'b1 || o_stalls != 3) begin failures++; $display("FAIL b2b_lw got=%h/%b/%0d exp=cafef00d/1/3", o_wdata, o_wreg, o_stalls); end
        run_op(1'b0, 1'b1, 3'b010, 32'h404, 32'h1122_3344, 5'd11, 1'b0, 4, 32'h0);
        checks++; if (o_w !== 1'b1 || o_data !== 32'h1122_3344 || o_state !== 2'd3) begin failures++; $display("FAIL b2b_sw got=%b/%h/%0d exp=1/11223344/3", o_w, o_data, o_state); end
        checks++; if (o_stalls != 5) begin failures++; $display("FAIL b2b_sw_stall got=%0d exp=5", o_stalls); end
        idle_inputs();
        repeat (3) @(negedge clk);
        checks++; if (sync_edges - e0 != 2 || ram_sync_o !== s0) begin failures++; $display("FAIL b2b_toggles got=%0d/%b exp=2/%b", sync_edges - e0, ram_sync_o, s0); end
    endtask

    task automatic test_alu;
        int e0;
        e0 = sync_edges;
        @(posedge clk);
        #2;
        mem_re_i = 1'b0; mem_we_i = 1'b0; funct3_i = 3'b000; wdata_i = 32'h55; wd_i = 5'd4; wreg_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (stall_o !== 1'b0 || wdata_o !== 32'h55 || wreg_o !== 1'b1) begin failures++; $display("FAIL alu_pass got=%b/%h/%b exp=0/00000055/1", stall_o, wdata_o, wreg_o); end
        end
        checks++; if (sync_edges != e0) begin failures++; $display("FAIL alu_toggle got=%0d exp=0", sync_edges - e0); end
        run_op(1'b1, 1'b0, 3'b011, 32'h10, 32'h77, 5'd5, 1'b1, 2, 32'h0);
        checks++; if (o_stalls != 0 || o_wdata !== 32'h77 || o_wreg !== 1'b1 || o_toggles != 0) begin failures++; $display("FAIL illegal_f3 got=%0d/%h/%b/%0d exp=0/00000077/1/0", o_stalls, o_wdata, o_wreg, o_toggles); end
        run_op(1'b1, 1'b1, 3'b010, 32'h10, 32'h88, 5'd5, 1'b1, 2, 32'h0);
        checks++; if (o_stalls != 0 || o_wdata !== 32'h88 || o_wreg !== 1'b1 || o_toggles != 0) begin failures++; $display("FAIL re_and_we got=%0d/%h/%b/%0d exp=0/00000088/1/0", o_stalls, o_wdata, o_wreg, o_toggles); end
        idle_inputs();
    endtask

    task automatic test_async_reset;
        ctrl_lat = 50;
        @(posedge clk);
        #2;
        mem_re_i = 1'b1; mem_we_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h300; wreg_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (stall_o !== 1'b1 || ram_r_req_o !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b/%b exp=1/1", stall_o, ram_r_req_o); end
        #1;
        rst = 1'b0;
        mem_re_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0 || ram_r_req_o !== 1'b0 || ram_sync_o !== 1'b0) begin failures++; $display("FAIL arst_drop got=%b/%b/%b exp=0/0/0", stall_o, ram_r_req_o, ram_sync_o); end
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        run_op(1'b1, 1'b0, 3'b000, 32'h308, 32'h0, 5'd12, 1'b1, 3, 32'h5555_007F);
        checks++; if (o_stalls != 4 || o_wdata !== 32'h0000_007F || o_wreg !== 1'b1 || o_toggles != 1) begin failures++; $display("FAIL arst_after got=%0d/%h/%b/%0d exp=4/0000007f/1/1", o_stalls, o_wdata, o_wreg, o_toggles); end
        idle_inputs();
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            logic        re, we, wr, mem;
            logic [2:0]  f3;
            logic [31:0] a, d, raw;
            logic [4:0]  rd;
            int          lat;
            re  = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            f3  = 3'($urandom_range(0, 7));
            rd  = 5'($urandom_range(0, 31));
            a   = $urandom;
            d   = $urandom;
            raw = $urandom;
            lat = int'($urandom_range(1, 8));
            mem = (re != we) && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
            run_op(re, we, f3, a, d, rd, wr, lat, raw);
            checks++; if (o_timeout !== 1'b0) begin failures++; $display("FAIL rnd%0d_timeout got=%b exp=0", i, o_timeout); end
            checks++; if (o_wd !== rd) begin failures++; $display("FAIL rnd%0d_wd got=%0d exp=%0d", i, o_wd, rd); end
            if (mem) begin
                checks++; if (o_stalls != lat + 1) begin failures++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", i, o_stalls, lat + 1); end
                checks++; if (o_r !== re || o_w !== we) begin failures++; $display("FAIL rnd%0d_req got=r%b w%b exp=r%b w%b", i, o_r, o_w, re, we); end
                checks++; if (o_addr !== a || o_state !== ref_state(f3)) begin failures++; $display("FAIL rnd%0d_addr_state got=%h/%0d exp=%h/%0d", i, o_addr, o_state, a, ref_state(f3)); end
                checks++; if (o_wreg !== (wr & re) || o_wreg_stall !== 1'b0) begin failures++; $display("FAIL rnd%0d_wreg got=%b/%b exp=%b/0", i, o_wreg, o_wreg_stall, wr & re); end
                checks++; if (o_wdata !== (re ? ref_load(f3, raw) : d)) begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, o_wdata, re ? ref_load(f3, raw) : d); end
                checks++; if (o_toggles != 1 || o_req_done !== 1'b0) begin failures++; $display("FAIL rnd%0d_sync got=%0d/%b exp=1/0", i, o_toggles, o_req_done); end
                if (we) begin
                    checks++; if (o_data !== d) begin failures++; $display("FAIL rnd%0d_sdata got=%h exp=%h", i, o_data, d); end
                end
            end else begin
                checks++; if (o_stalls != 0 || o_toggles != 0) begin failures++; $display("FAIL rnd%0d_nomem got=%0d/%0d exp=0/0", i, o_stalls, o_toggles); end
                checks++; if (o_wdata !== d || o_wreg !== wr) begin failures++; $display("FAIL rnd%0d_pass got=%h/%b exp=%h/%b", i, o_wdata, o_wreg, d, wr); end
            end
            idle_inputs();
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lhu_lh();
        test_sh();
        test_back_to_back();
        test_alu();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline MEM stage. Sits between the EX/MEM pipeline latch and the memory controller. It turns load/store micro-ops into toggle-handshake requests on the controller's RAM port and holds the pipeline with `stall_o` until the transfer completes. It then sign- or zero-extends load data and forwards the writeback bundle to the MEM/WB latch.

## Interface
- Parameters: none.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `mem_re_i`  in  1  instruction is a load.
- `mem_we_i`  in  1  instruction is a store.
- `funct3_i`  in  3  width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr_i`  in  32  effective address.
- `wdata_i`  in  32  store data, or ALU result for non-loads.
- `wd_i`  in  5  destination register.
- `wreg_i`  in  1  register-write enable.
- `wd_o`  out  5  = `wd_i`.
- `wreg_o`  out  1  writeback enable; forced 0 for stores and whenever `stall_o`=1.
- `wdata_o`  out  32  writeback value.
- `stall_o`  out  1  pipeline hold request.
- `ram_r_req_o`  out  1  read request to the controller.
- `ram_w_req_o`  out  1  write request to the controller.
- `ram_addr_o`  out  32  base byte address.
- `ram_data_o`  out  32  store data, byte 0 in [7:0].
- `ram_state_o`  out  2  bytes−1: B=0, H=1, W=3. The value 2 is never driven.
- `ram_sync_o`  out  1  request toggle.
- `ram_sync_i`  in  1  completion toggle from the controller.
- `ram_data_i`  in  32  load data; only the low 1/2/4 bytes are valid.

## Operation
- Handshake: a request is pending while `ram_sync_o != ram_sync_i`. The stage issues a request by toggling `ram_sync_o`. The transfer is complete when the controller toggles `ram_sync_i` back to equality. `ram_data_i` is valid from that cycle on.
- FSM states: IDLE, WAIT, DONE.
- IDLE, with a valid op (`mem_re_i ^ mem_we_i`, funct3 legal):
  - `stall_o`=1 combinationally.
  - On the edge: latch addr, wdata and funct3 into request registers; set `ram_r_req_o`/`ram_w_req_o`; toggle `ram_sync_o`; go to WAIT.
- IDLE, otherwise: no request. `stall_o`=0, `wdata_o`=`wdata_i`, `wreg_o`=`wreg_i`.
- Illegal funct3 (011, 110, 111), or re&we both set: treated as a non-memory op. No request and `wreg_o`=`wreg_i`.
- WAIT:
  - `stall_o`=1.
  - Request outputs are held stable.
  - When `ram_sync_i == ram_sync_o`: latch the extended load result into `rdata`, clear both req outputs, go to DONE.
- DONE:
  - `stall_o`=0.
  - `wdata_o` = `rdata` for loads, `wdata_i` for stores. `wreg_o` = `wreg_i` & load.
  - No new request is issued, because the inputs still hold the same instruction.
  - Next edge goes to IDLE.
- Load extension:
  - LB: {{24{d[7]}}, d[7:0]}.
  - LH: {{16{d[15]}}, d[15:0]}.
  - LW: d.
  - LBU and LHU: zero-extend.
  - Bits of `ram_data_i` above the access width are ignored; the controller leaves stale values there.
- Stores pass `wdata_i` unmodified to `ram_data_o`. The controller selects the bytes using `ram_state_o`.
- An issued request cannot be cancelled. The stage has no flush input, and the hazard unit must not flush while `stall_o`=1.
- Misaligned addresses are forwarded unchanged, with no trap.

## Timing
- Reset values: state IDLE, `ram_sync_o`=0, `ram_r_req_o`=0, `ram_w_req_o`=0, `ram_addr_o`=0, `ram_data_o`=0, `ram_state_o`=0, `rdata`=0. Combinational outputs follow IDLE rules.
- All `ram_*_o` outputs are registered. `stall_o`, `wreg_o` and `wdata_o` are combinational from state and inputs.
- Request latency: op present in cycle 0 → `ram_sync_o` toggles and req asserts at the cycle-0 edge.
- Completion latency: sync equality seen in WAIT cycle k → DONE in cycle k+1 → IDLE in k+2.
- Total stall = 1 + (controller cycles) + 0. The DONE cycle is unstalled.
- Back-to-back memory ops: the second is issued from IDLE two cycles after completion is seen. `ram_sync_o` alternates 0→1→0.
- Async reset during WAIT: return to IDLE immediately with `ram_sync_o`=0. The controller must be reset in the same event.
- `ram_sync_i` changing while in IDLE or DONE is ignored.

## Test plan
- LB at 0x100, controller returns 0x12345680 after 6 cycles:
  - `ram_state_o`=0, `ram_r_req_o`=1, `stall_o`=1 for 7 cycles.
  - DONE: `wdata_o`=0xFFFFFF80, `wreg_o`=1.
- LHU at 0x204, data 0xAAAA8001 → `ram_state_o`=1, DONE `wdata_o`=0x00008001. LH with the same data → 0xFFFF8001.
- SH at 0x1002, `wdata_i`=0xDEADBEEF:
  - `ram_w_req_o`=1, `ram_addr_o`=0x1002, `ram_data_o`=0xDEADBEEF, `ram_state_o`=1.
  - `wreg_o`=0 throughout.
- LW then SW back-to-back: `ram_sync_o` goes 0→1→0, exactly two requests, no duplicate issue from DONE.
- ADD result 0x55 with `wreg_i`=1 and no mem op → `stall_o`=0 in every cycle, `wdata_o`=0x55, no sync toggle.
- `rst` low mid-WAIT → `stall_o` and req drop asynchronously, `ram_sync_o`=0. After release, a new LB completes normally.
